// File: rtl/sensor_echo_responder.sv
// Ultrasonic ranger emulator: answers an accepted trigger pulse with an echo whose width encodes distance_cm.
// Optional SENSOR_ECHO_STATS_EN adds accepted/ignored trigger counters.
module sensor_echo_responder #(
  parameter int unsigned DIST_W       = 8,
  parameter int unsigned TRIG_MIN_CYC = 1000,
  parameter int unsigned DELAY_CYC    = 25000,
  parameter int unsigned CYC_PER_CM   = 5800,
  parameter int unsigned MAX_CM       = 200,
  parameter int unsigned TIMEOUT_CYC  = 1900000,
  parameter int unsigned HOLDOFF_CYC  = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trig_i,
  input  logic [DIST_W-1:0] distance_cm,
  output logic              echo_o,
  output logic              busy_o,
  output logic              trig_ignored_o
`ifdef SENSOR_ECHO_STATS_EN
  ,
  output logic [15:0]       trig_count_o,
  output logic [15:0]       ign_count_o
`endif
);

  localparam int unsigned RANGE_MAX = MAX_CM * CYC_PER_CM;
  localparam int unsigned ECHO_MAX  = (RANGE_MAX > TIMEOUT_CYC) ? RANGE_MAX : TIMEOUT_CYC;
  localparam int unsigned MAX_A     = (ECHO_MAX > DELAY_CYC) ? ECHO_MAX : DELAY_CYC;
  localparam int unsigned MAX_B     = (MAX_A > HOLDOFF_CYC) ? MAX_A : HOLDOFF_CYC;
  localparam int unsigned CNT_MAX   = (MAX_B > TRIG_MIN_CYC) ? MAX_B : TRIG_MIN_CYC;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG    = 3'd1,
    DELAY   = 3'd2,
    ECHO    = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DIST_W-1:0]   dist_q, dist_d;
  logic [CNT_W-1:0]    echo_len;
  logic                trig_s1_q, trig_s2_q, trig_s3_q;
  logic [1:0]          warm_q;
  logic                armed_q, armed_d;
  logic                trig_rise;
  logic                echo_q, echo_d;
  logic                busy_q, busy_d;
  logic                ign_q, ign_d;

  // Synchronizer plus warm-up: a rise only counts once a genuine low has been sampled after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_s1_q <= 1'b0;
      trig_s2_q <= 1'b0;
      trig_s3_q <= 1'b0;
      warm_q    <= 2'b00;
      armed_q   <= 1'b0;
    end else begin
      trig_s1_q <= trig_i;
      trig_s2_q <= trig_s1_q;
      trig_s3_q <= trig_s2_q;
      warm_q    <= {warm_q[0], 1'b1};
      armed_q   <= armed_d;
    end
  end

  assign armed_d   = armed_q | (warm_q[1] & ~trig_s2_q);
  assign trig_rise = armed_q & trig_s2_q & ~trig_s3_q;

  // Echo width from the latched distance; zero or out-of-range reports a timeout.
  always_comb begin
    if ((dist_q == '0) || (32'(dist_q) > MAX_CM)) begin
      echo_len = CNT_W'(TIMEOUT_CYC);
    end else begin
      echo_len = CNT_W'(32'(dist_q) * CYC_PER_CM);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dist_q  <= '0;
      echo_q  <= 1'b0;
      busy_q  <= 1'b0;
      ign_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dist_q  <= dist_d;
      echo_q  <= echo_d;
      busy_q  <= busy_d;
      ign_q   <= ign_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dist_d  = dist_q;
    unique case (state_q)
      IDLE: begin
        if (trig_rise) begin
          state_d = TRIG;
          cnt_d   = CNT_W'(1);
        end
      end
      TRIG: begin
        if (!trig_s2_q) begin
          if (cnt_q >= CNT_W'(TRIG_MIN_CYC)) begin
            state_d = DELAY;
            cnt_d   = CNT_W'(DELAY_CYC - 1);
            dist_d  = distance_cm;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else if (cnt_q < CNT_W'(TRIG_MIN_CYC)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DELAY: begin
        if (cnt_q == '0) begin
          state_d = ECHO;
          cnt_d   = echo_len - CNT_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ECHO: begin
        if (cnt_q == '0) begin
          state_d = HOLDOFF;
          cnt_d   = CNT_W'(HOLDOFF_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLDOFF: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    echo_d = (state_d == ECHO);
    busy_d = (state_d == DELAY) || (state_d == ECHO) || (state_d == HOLDOFF);
    ign_d  = trig_rise &&
             ((state_q == DELAY) || (state_q == ECHO) || (state_q == HOLDOFF));
  end

  assign echo_o         = echo_q;
  assign busy_o         = busy_q;
  assign trig_ignored_o = ign_q;

`ifdef SENSOR_ECHO_STATS_EN
  logic [15:0] trig_cnt_q, ign_cnt_q;

  // Free-running wrap-around counters of accepted and ignored triggers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_cnt_q <= '0;
      ign_cnt_q  <= '0;
    end else begin
      if ((state_q == TRIG) && (state_d == DELAY)) begin
        trig_cnt_q <= trig_cnt_q + 16'd1;
      end
      if (ign_d) begin
        ign_cnt_q <= ign_cnt_q + 16'd1;
      end
    end
  end

  assign trig_count_o = trig_cnt_q;
  assign ign_count_o  = ign_cnt_q;
`endif

endmodule
